fxp_div_seq: RTL and testbench

- Sequential signed fixed-point divider; the inverse operation of the team's combinational Q-format multiplier.
- Operands and result are N-bit two's-complement values with Q fractional bits.
- Computes quotient = dividend / divisor using a restoring algorithm, one quotient bit per clock.
- Sits in the datapath beside the multiplier; uses a valid/ready handshake on both input and output.

---
 rtl/fxp_pkg.sv | 40 ++++
 rtl/fxp_div_step.sv | 23 ++
 rtl/fxp_div_seq.sv | 188 ++++++++++++++++++
 tb/tb_fxp_div_seq.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// Shared types and helpers for the sequential Q-format divider.
// Holds the default word/fraction widths, the divider FSM state type,
// and the magnitude-saturation and sign-application helpers.
package fxp_pkg;

  localparam int N_DEF = 32;
  localparam int Q_DEF = 18;

  // Helpers work on a wide fixed container so any legal N/Q pair fits
  // (the raw magnitude is at most N+Q bits wide).
  localparam int MAXW = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic            ovf;
    logic [MAXW-1:0] mag;
  } sat_t;

  // Clamp a raw quotient magnitude to the largest positive N-bit value.
  // Anything above 2^(n-1)-1 means some bit above the result field is set.
  function automatic sat_t sat_mag(input logic [MAXW-1:0] raw, input int n);
    sat_t            r;
    logic [MAXW-1:0] lim;
    lim   = (MAXW'(1) << (n - 1)) - MAXW'(1);
    r.ovf = (raw > lim);
    r.mag = r.ovf ? lim : raw;
    return r;
  endfunction

  // Apply the sign to a magnitude; a negative zero collapses to zero.
  function automatic logic [MAXW-1:0] to_twos(input logic sign, input logic [MAXW-1:0] mag);
    return (sign && (mag != '0)) ? (~mag + MAXW'(1)) : mag;
  endfunction

endpackage

// File: rtl/fxp_div_step.sv
// One restoring-division step: shift the partial remainder left, bring in
// the next dividend bit and subtract the divisor when it fits.
module fxp_div_step
  import fxp_pkg::*;
#(
  parameter int W = N_DEF - 1
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_div,
  input  logic         i_bit,
  output logic [W-1:0] o_rem,
  output logic         o_qbit
);

  // The shifted remainder needs one extra bit; after a subtraction the
  // result is below the divisor, so W bits of modular arithmetic suffice.
  logic [W:0] w_shift;

  assign w_shift = {i_rem, i_bit};
  assign o_qbit  = (w_shift >= {1'b0, i_div});
  assign o_rem   = o_qbit ? (w_shift[W-1:0] - i_div) : w_shift[W-1:0];

endmodule

// File: rtl/fxp_div_seq.sv
// Sequential signed Q-format divider, one quotient bit per clock.
// Operands are converted to sign + magnitude, divided with a restoring
// loop, then saturated and re-signed in the first DONE cycle.
// Define FXP_DIV_ROUND_EN to round half away from zero (one extra
// iteration); otherwise the result truncates toward zero.
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high. in_ready is high only in IDLE; out_valid stays high with
// quotient/ovf/dbz frozen until out_ready is seen, and the next operand
// pair can be taken no earlier than the cycle after that.
module fxp_div_seq
  import fxp_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic         ovf,
  output logic         dbz,
  output state_t       dbg_state
);

  // Width of the extended dividend |dividend| << Q.
  localparam int EW = N - 1 + Q;
`ifdef FXP_DIV_ROUND_EN
  // One extra iteration produces the bit just below the result LSB.
  localparam int QW = EW + 1;
`else
  localparam int QW = EW;
`endif
  localparam int CW = $clog2(QW + 1);
  localparam logic [CW-1:0] LAST = CW'(QW - 1);

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_sign;
  logic           r_neg_a;
  logic           r_dbz;
  logic [N-2:0]   r_dmag;
  logic [N-2:0]   r_rem;
  logic [EW-1:0]  r_ext;
  logic [QW-1:0]  r_quo;
  logic           r_in_ready;
  logic           r_out_valid;
  logic [N-1:0]   r_quotient;
  logic           r_ovf;
  logic           r_dbz_o;

  logic [N-2:0]   w_mag_a;
  logic [N-2:0]   w_mag_b;
  logic [N-2:0]   w_rem_nxt;
  logic           w_qbit;
  logic [MAXW-1:0] w_raw;
  sat_t           w_sat;
  logic [N-1:0]   w_q_res;
  logic [MAXW-N-1:0] w_unused_tw_hi;
  logic [N-1:0]   w_dbz_q;

  // Magnitude of a two's-complement word in N-1 bits; the most negative
  // value has no positive counterpart and is clamped to 2^(N-1)-1.
  function automatic logic [N-2:0] abs_clamp(input logic [N-1:0] x);
    if (!x[N-1]) begin
      return x[N-2:0];
    end else if (x[N-2:0] == '0) begin
      return '1;
    end else begin
      return ~x[N-2:0] + (N-1)'(1);
    end
  endfunction

  assign w_mag_a = abs_clamp(dividend);
  assign w_mag_b = abs_clamp(divisor);

  fxp_div_step #(
    .W(N - 1)
  ) u_step (
    .i_rem (r_rem),
    .i_div (r_dmag),
    .i_bit (r_ext[EW-1]),
    .o_rem (w_rem_nxt),
    .o_qbit(w_qbit)
  );

  // Raw magnitude, rounded up when the extra bit below the LSB is set.
  always_comb begin
`ifdef FXP_DIV_ROUND_EN
    w_raw = MAXW'(r_quo[QW-1:1]) + MAXW'(r_quo[0]);
`else
    w_raw = MAXW'(r_quo);
`endif
  end

  assign w_sat = sat_mag(w_raw, N);
  assign {w_unused_tw_hi, w_q_res} = to_twos(r_sign, w_sat.mag);

  // Division by zero saturates toward the sign of the dividend.
  assign w_dbz_q = r_neg_a ? {1'b1, {(N-2){1'b0}}, 1'b1} : {1'b0, {(N-1){1'b1}}};

  // Control FSM, shift/remainder datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sign      <= 1'b0;
      r_neg_a     <= 1'b0;
      r_dbz       <= 1'b0;
      r_dmag      <= '0;
      r_rem       <= '0;
      r_ext       <= '0;
      r_quo       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quotient  <= '0;
      r_ovf       <= 1'b0;
      r_dbz_o     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_sign     <= dividend[N-1] ^ divisor[N-1];
            r_neg_a    <= dividend[N-1];
            r_dmag     <= w_mag_b;
            r_ext      <= {w_mag_a, {Q{1'b0}}};
            r_rem      <= '0;
            r_quo      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            if (divisor == '0) begin
              r_dbz   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_dbz   <= 1'b0;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= {r_quo[QW-2:0], w_qbit};
          r_ext <= {r_ext[EW-2:0], 1'b0};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          // First DONE cycle formats the result; afterwards hold it.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            if (r_dbz) begin
              r_quotient <= w_dbz_q;
              r_ovf      <= 1'b0;
              r_dbz_o    <= 1'b1;
            end else begin
              r_quotient <= w_q_res;
              r_ovf      <= w_sat.ovf;
              r_dbz_o    <= 1'b0;
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign quotient  = r_quotient;
  assign ovf       = r_ovf;
  assign dbz       = r_dbz_o;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fxp_div_seq.sv
// Directed bench for fxp_div_seq at N=32, Q=18 with hand-computed vectors.
module tb_fxp_div_seq;
  import fxp_pkg::*;

  localparam int N = 32;
  localparam int Q = 18;
  localparam int LIM = 200;
`ifdef FXP_DIV_ROUND_EN
  localparam int LAT = 51;
  localparam logic [N-1:0] EXP_TWO_THIRDS = 32'h0002AAAB;
  localparam logic [N-1:0] EXP_M7_2 = 32'hFFFFFFFC;
`else
  localparam int LAT = 50;
  localparam logic [N-1:0] EXP_TWO_THIRDS = 32'h0002AAAA;
  localparam logic [N-1:0] EXP_M7_2 = 32'hFFFFFFFD;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic         ovf;
  logic         dbz;
  state_t       dbg_state;

  int n_vec;
  int n_err;

  fxp_div_seq #(
    .N(N),
    .Q(Q)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .ovf      (ovf),
    .dbz      (dbz),
    .dbg_state(dbg_state)
  );

  // Clock and reset-free clock generator.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operand pair, measure latency, check result, optionally
  // stall the consumer and poke in_valid during CALC, then retire it.
  task automatic run_vec(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] exp_q, input logic exp_ovf, input logic exp_dbz,
                         input int exp_lat, input int hold, input bit poke);
    int lat;
    @(posedge clk); #1;
    check({tag, "_in_ready_idle"}, 64'(in_ready), 64'(1));
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat = 0;
    while (out_valid !== 1'b1 && lat < LIM) begin
      if (poke && lat == 5) begin
        in_valid = 1'b1;
        dividend = 32'h00400000;
        divisor  = 32'h00010000;
      end
      if (poke && lat == 8) in_valid = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_quotient"}, 64'(quotient), 64'(exp_q));
    check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
    check({tag, "_dbz"}, 64'(dbz), 64'(exp_dbz));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
      check({tag, "_hold_quotient"}, 64'(quotient), 64'(exp_q));
      check({tag, "_hold_flags"}, 64'({ovf, dbz}), 64'({exp_ovf, exp_dbz}));
      check({tag, "_hold_in_ready"}, 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_retire_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_retire_in_ready"}, 64'(in_ready), 64'(1));
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_quotient", 64'(quotient), 64'(0));
    check("rst_flags", 64'({ovf, dbz}), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Main function.
    run_vec("div_6_2", 32'h00180000, 32'h00080000, 32'h000C0000, 1'b0, 1'b0, LAT, 0, 1'b0);
    run_vec("div_m1p5_0p5", 32'hFFFA0000, 32'h00020000, 32'hFFF40000, 1'b0, 1'b0, LAT, 0, 1'b0);
    run_vec("div_2_3", 32'h00080000, 32'h000C0000, EXP_TWO_THIRDS, 1'b0, 1'b0, LAT, 0, 1'b0);
    run_vec("div_m7lsb_2", 32'hFFFFFFF9, 32'h00080000, EXP_M7_2, 1'b0, 1'b0, LAT, 0, 1'b0);

    // Saturation and clamping boundaries.
    run_vec("ovf_pos", 32'h40000000, 32'h00010000, 32'h7FFFFFFF, 1'b1, 1'b0, LAT, 0, 1'b0);
    run_vec("ovf_neg", 32'hC0000000, 32'h00010000, 32'h80000001, 1'b1, 1'b0, LAT, 0, 1'b0);
    run_vec("min_clamp", 32'h80000000, 32'h7FFFFFFF, 32'hFFFC0000, 1'b0, 1'b0, LAT, 0, 1'b0);
    run_vec("neg_zero", 32'h00000000, 32'hFFFC0000, 32'h00000000, 1'b0, 1'b0, LAT, 0, 1'b0);

    // Division by zero.
    run_vec("dbz_pos", 32'h00140000, 32'h00000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1, 0, 1'b0);
    run_vec("dbz_neg", 32'hFFEC0000, 32'h00000000, 32'h80000001, 1'b0, 1'b1, 1, 0, 1'b0);

    // Consumer stall with in_valid poked during CALC.
    run_vec("stall_poke", 32'h00180000, 32'h00080000, 32'h000C0000, 1'b0, 1'b0, LAT, 10, 1'b1);

    // Reset in the middle of CALC.
    @(posedge clk); #1;
    dividend = 32'h00080000;
    divisor  = 32'h000C0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_calc_state", 64'(dbg_state), 64'(CALC));
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_state", 64'(dbg_state), 64'(IDLE));
    check("midrst_quotient", 64'(quotient), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("after_rst", 32'hFFFA0000, 32'h00020000, 32'hFFF40000, 1'b0, 1'b0, LAT, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
